// File: rtl/clk_gen_pkg.sv
// Shared types and constants for the divider bank and its output selector.
package clk_gen_pkg;

  typedef enum logic {
    SEL_IDLE = 1'b0,
    SEL_WAIT = 1'b1
  } sel_state_t;

  localparam int DIV_W_DEF = 16;
  localparam int SEL_W_DEF = 2;
  localparam int SEL_NONE  = -1;

  // Maps a requested selector onto a channel index, or SEL_NONE when no such channel exists.
  function automatic int sel_index(input int sel, input int num_ch);
    return (sel < num_ch) ? sel : SEL_NONE;
  endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: 50% duty output with a half-period shadow that only
// reloads at toggle boundaries, so a ratio change never shortens a phase.
module clk_div_ch #(
  parameter int DIV_W   = 16,
  parameter int RST_DIV = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_restart,
  input  logic [DIV_W-1:0] i_half,
  output logic             o_out,
  output logic             o_tick
);

  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_shadow;
  logic             r_out;
  logic             r_tick;
  logic [DIV_W-1:0] w_h;
  logic             w_wrap;
  logic             w_run;

  assign w_h    = (r_shadow == '0) ? DIV_W'(1) : r_shadow;
  assign w_wrap = (r_cnt == (w_h - DIV_W'(1)));
  // A channel being disabled still finishes a high phase before freezing.
  assign w_run  = i_en | r_out;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt    <= '0;
      r_shadow <= DIV_W'(RST_DIV);
      r_out    <= 1'b0;
      r_tick   <= 1'b0;
    end else if (i_restart) begin
      r_cnt    <= '0;
      r_shadow <= i_half;
      r_out    <= 1'b0;
      r_tick   <= 1'b0;
    end else if (w_run) begin
      if (w_wrap) begin
        r_cnt    <= '0;
        r_shadow <= i_half;
        r_out    <= ~r_out;
        r_tick   <= ~r_out;
      end else begin
        r_cnt  <= r_cnt + DIV_W'(1);
        r_tick <= 1'b0;
      end
    end else begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end
  end

  assign o_out  = r_out;
  assign o_tick = r_tick;

endmodule

// File: rtl/clk_div_bank.sv
// Bank of programmable dividers with a registered selector that only switches
// channels while both the old and new outputs are low.
module clk_div_bank
  import clk_gen_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int DIV_W   = DIV_W_DEF,
  parameter int SEL_W   = SEL_W_DEF,
  parameter int RST_DIV = 1
) (
  input  logic                    CLK_REF,
  input  logic                    RST,
  input  logic [NUM_CH-1:0]       CH_EN,
  input  logic [NUM_CH-1:0]       CH_RESTART,
  input  logic [NUM_CH*DIV_W-1:0] CH_HALF,
  output logic [NUM_CH-1:0]       CH_OUT,
  output logic [NUM_CH-1:0]       CH_TICK,
  input  logic [SEL_W-1:0]        CLK_CTL,
  output logic                    CLK_MUXOUT,
  output logic                    SEL_BUSY,
  output logic [SEL_W-1:0]        SEL_ACT
);

  localparam int SEL_N = 2 ** SEL_W;

  logic [NUM_CH-1:0] w_ch_out;
  logic [NUM_CH-1:0] w_ch_tick;
  logic [SEL_N-1:0]  w_out_pad;
  logic              w_ctl_valid;

  sel_state_t        r_state;
  sel_state_t        w_state_next;
  logic [SEL_W-1:0]  r_target;
  logic [SEL_W-1:0]  w_target_next;
  logic [SEL_W-1:0]  r_sel_act;
  logic [SEL_W-1:0]  w_sel_act_next;
  logic              r_busy;
  logic              w_busy_next;
  logic              r_muxout;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      clk_div_ch #(
        .DIV_W   (DIV_W),
        .RST_DIV (RST_DIV)
      ) u_ch (
        .i_clk     (CLK_REF),
        .i_rst     (RST),
        .i_en      (CH_EN[gi]),
        .i_restart (CH_RESTART[gi]),
        .i_half    (CH_HALF[gi*DIV_W +: DIV_W]),
        .o_out     (w_ch_out[gi]),
        .o_tick    (w_ch_tick[gi])
      );
    end
  endgenerate

  // Pad to the full selector range so any selector value indexes safely.
  assign w_out_pad   = SEL_N'(w_ch_out);
  assign w_ctl_valid = (sel_index(int'(CLK_CTL), NUM_CH) != SEL_NONE);

  always_comb begin
    w_state_next   = r_state;
    w_target_next  = r_target;
    w_sel_act_next = r_sel_act;
    w_busy_next    = r_busy;
    case (r_state)
      SEL_IDLE: begin
        if (w_ctl_valid && (CLK_CTL != r_sel_act)) begin
          w_target_next = CLK_CTL;
          w_busy_next   = 1'b1;
          w_state_next  = SEL_WAIT;
        end
      end
      SEL_WAIT: begin
        if (!w_out_pad[r_sel_act] && !w_out_pad[r_target]) begin
          w_sel_act_next = r_target;
          w_busy_next    = 1'b0;
          w_state_next   = SEL_IDLE;
        end else if (w_ctl_valid) begin
          w_target_next = CLK_CTL;
        end
      end
      default: w_state_next = SEL_IDLE;
    endcase
  end

  always_ff @(posedge CLK_REF) begin
    if (RST) begin
      r_state   <= SEL_IDLE;
      r_target  <= '0;
      r_sel_act <= '0;
      r_busy    <= 1'b0;
      r_muxout  <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_target  <= w_target_next;
      r_sel_act <= w_sel_act_next;
      r_busy    <= w_busy_next;
      r_muxout  <= w_out_pad[r_sel_act];
    end
  end

  assign CH_OUT     = w_ch_out;
  assign CH_TICK    = w_ch_tick;
  assign CLK_MUXOUT = r_muxout;
  assign SEL_BUSY   = r_busy;
  assign SEL_ACT    = r_sel_act;

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed bench for clk_div_bank: expected tick and selector-switch cycles are
// queued by the stimulus and consumed by an independent negedge monitor.
module tb_clk_div_bank;

  localparam int NUM_CH = 4;
  localparam int DIV_W  = 16;
  localparam int SEL_W  = 3;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic [NUM_CH-1:0]       ch_en = '0;
  logic [NUM_CH-1:0]       ch_restart = '0;
  logic [NUM_CH*DIV_W-1:0] ch_half = '0;
  logic [SEL_W-1:0]        clk_ctl = '0;
  logic [NUM_CH-1:0]       ch_out;
  logic [NUM_CH-1:0]       ch_tick;
  logic                    muxout;
  logic                    busy;
  logic [SEL_W-1:0]        sel_act;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  bit   mon_en   = 1'b0;
  int   tick_q[$];
  int   sel_q[$];
  logic [SEL_W-1:0] prev_act = '0;

  clk_div_bank #(
    .NUM_CH  (NUM_CH),
    .DIV_W   (DIV_W),
    .SEL_W   (SEL_W),
    .RST_DIV (1)
  ) dut (
    .CLK_REF    (clk),
    .RST        (rst),
    .CH_EN      (ch_en),
    .CH_RESTART (ch_restart),
    .CH_HALF    (ch_half),
    .CH_OUT     (ch_out),
    .CH_TICK    (ch_tick),
    .CLK_CTL    (clk_ctl),
    .CLK_MUXOUT (muxout),
    .SEL_BUSY   (busy),
    .SEL_ACT    (sel_act)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d got=timeout required=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h required=%0h", name, cyc, act, exp);
    end else begin
      $display("ok   %s cyc=%0d value=%0h", name, cyc, act);
    end
  endtask

  task automatic push_ticks(input int ch, input int first, input int period, input int last);
    for (int c = first; c <= last; c += period) tick_q.push_back(c * 16 + ch);
    tick_q.sort();
  endtask

  task automatic restart_ch(input int ch, input int half);
    ch_half[ch*DIV_W +: DIV_W] = half[DIV_W-1:0];
    ch_restart[ch] = 1'b1;
    step(1);
    ch_restart[ch] = 1'b0;
  endtask

  task automatic stop_ch(input int ch);
    ch_restart[ch] = 1'b1;
    ch_en[ch] = 1'b0;
    step(1);
    ch_restart[ch] = 1'b0;
  endtask

  // Monitor: every tick and every SEL_ACT change must match the head of its queue.
  always @(negedge clk) begin
    if (mon_en) begin
      while (tick_q.size() > 0 && (tick_q[0] / 16) < cyc) begin
        n_checks++;
        n_fail++;
        $display("FAIL tick_missing ch=%0d got=none required_cyc=%0d", tick_q[0] % 16, tick_q[0] / 16);
        void'(tick_q.pop_front());
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_tick[i] === 1'b1) begin
          n_checks++;
          if (tick_q.size() > 0 && tick_q[0] == cyc * 16 + i) begin
            void'(tick_q.pop_front());
            $display("ok   tick ch=%0d cyc=%0d", i, cyc);
          end else begin
            n_fail++;
            $display("FAIL tick_unexpected ch=%0d got_cyc=%0d required=no_tick", i, cyc);
          end
        end
      end
      while (sel_q.size() > 0 && (sel_q[0] / 16) < cyc) begin
        n_checks++;
        n_fail++;
        $display("FAIL sel_missing got=%0d required=%0d at_cyc=%0d", sel_act, sel_q[0] % 16, sel_q[0] / 16);
        void'(sel_q.pop_front());
      end
      if (sel_act !== prev_act) begin
        n_checks++;
        if (sel_q.size() > 0 && sel_q[0] == cyc * 16 + int'(sel_act)) begin
          void'(sel_q.pop_front());
          $display("ok   sel_switch act=%0d cyc=%0d", sel_act, cyc);
        end else begin
          n_fail++;
          $display("FAIL sel_unexpected cyc=%0d got=%0d required=%0d", cyc, sel_act, prev_act);
        end
        prev_act = sel_act;
      end
    end
  end

  initial begin
    int t;
    int r;
    int u;
    int x;
    int e;

    // Reset state
    step(3);
    check("rst_ch_out", 32'(ch_out), 32'd0);
    check("rst_ch_tick", 32'(ch_tick), 32'd0);
    check("rst_muxout", 32'(muxout), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sel_act", 32'(sel_act), 32'd0);
    rst = 1'b0;
    step(1);
    mon_en = 1'b1;

    // ch0 at H=2: period 4, first rise 2 cycles after enable
    restart_ch(0, 2);
    t = cyc;
    ch_en[0] = 1'b1;
    push_ticks(0, t + 2, 4, t + 12);
    for (int k = 1; k <= 8; k++) begin
      step(1);
      e = ((cyc - (t + 2)) < 0) ? 0 : ((((cyc - (t + 2)) % 4) < 2) ? 1 : 0);
      check("ch0_duty", 32'(ch_out[0]), 32'(e));
    end
    wait_until(t + 12);
    stop_ch(0);

    // ch1 at H=5, rewritten to 3 during the high phase
    restart_ch(1, 5);
    t = cyc;
    ch_en[1] = 1'b1;
    push_ticks(1, t + 5, 10, t + 5);
    push_ticks(1, t + 13, 6, t + 26);
    wait_until(t + 6);
    ch_half[1*DIV_W +: DIV_W] = 16'd3;
    wait_until(t + 9);
    check("ch1_high_kept", 32'(ch_out[1]), 32'd1);
    wait_until(t + 10);
    check("ch1_fall", 32'(ch_out[1]), 32'd0);
    wait_until(t + 12);
    check("ch1_low3", 32'(ch_out[1]), 32'd0);
    wait_until(t + 13);
    check("ch1_rise3", 32'(ch_out[1]), 32'd1);
    wait_until(t + 26);
    stop_ch(1);

    // ch2 at H=4, enable dropped mid-high, later re-enabled
    restart_ch(2, 4);
    t = cyc;
    ch_en[2] = 1'b1;
    push_ticks(2, t + 4, 8, t + 4);
    wait_until(t + 5);
    ch_en[2] = 1'b0;
    wait_until(t + 7);
    check("ch2_finish_high", 32'(ch_out[2]), 32'd1);
    wait_until(t + 8);
    check("ch2_low_after_dis", 32'(ch_out[2]), 32'd0);
    wait_until(t + 12);
    check("ch2_held_low", 32'(ch_out[2]), 32'd0);
    wait_until(t + 14);
    r = cyc;
    ch_en[2] = 1'b1;
    push_ticks(2, r + 4, 8, r + 13);
    wait_until(r + 3);
    check("ch2_reen_low", 32'(ch_out[2]), 32'd0);
    wait_until(r + 13);
    stop_ch(2);

    // Selector 0 -> 3 with ch0 H=2 and ch3 H=7
    ch_half[0*DIV_W +: DIV_W] = 16'd2;
    ch_half[3*DIV_W +: DIV_W] = 16'd7;
    ch_restart = 4'b1001;
    step(1);
    ch_restart = 4'b0000;
    t = cyc;
    u = t + 22;
    ch_en[0] = 1'b1;
    ch_en[3] = 1'b1;
    push_ticks(0, t + 2, 4, u);
    push_ticks(3, t + 7, 14, u + 14);
    wait_until(t + 3);
    check("mux_ch0_high", 32'(muxout), 32'd1);
    wait_until(t + 5);
    check("mux_ch0_low", 32'(muxout), 32'd0);
    wait_until(t + 8);
    clk_ctl = 3'd3;
    sel_q.push_back((t + 17) * 16 + 3);
    wait_until(t + 9);
    check("busy_set", 32'(busy), 32'd1);
    wait_until(t + 16);
    check("busy_hold", 32'(busy), 32'd1);
    wait_until(t + 17);
    check("busy_clear", 32'(busy), 32'd0);
    check("sel_act_3", 32'(sel_act), 32'd3);
    wait_until(t + 21);
    check("mux_ch3_low", 32'(muxout), 32'd0);
    wait_until(u);
    check("mux_ch3_high", 32'(muxout), 32'd1);

    // Switch back to ch0 while it is restarted at CH_HALF=0 (f/2)
    clk_ctl = 3'd0;
    ch_half[0*DIV_W +: DIV_W] = 16'd0;
    ch_restart[0] = 1'b1;
    push_ticks(0, u + 2, 2, u + 14);
    sel_q.push_back((u + 8) * 16 + 0);
    step(1);
    ch_restart[0] = 1'b0;
    check("busy_back", 32'(busy), 32'd1);
    wait_until(u + 7);
    check("busy_back_hold", 32'(busy), 32'd1);
    wait_until(u + 8);
    check("busy_back_clear", 32'(busy), 32'd0);
    wait_until(u + 10);
    check("mux_f2_low", 32'(muxout), 32'd0);
    wait_until(u + 11);
    check("mux_f2_high", 32'(muxout), 32'd1);

    // Reset in the middle of a pending switch
    wait_until(u + 12);
    clk_ctl = 3'd3;
    wait_until(u + 14);
    check("busy_before_rst", 32'(busy), 32'd1);
    rst = 1'b1;
    ch_en = '0;
    clk_ctl = '0;
    ch_half = '0;
    step(1);
    check("midrst_sel_act", 32'(sel_act), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_ch_out", 32'(ch_out), 32'd0);
    check("midrst_ch_tick", 32'(ch_tick), 32'd0);
    check("midrst_muxout", 32'(muxout), 32'd0);
    rst = 1'b0;
    step(1);

    // Out-of-range selector values are ignored
    clk_ctl = 3'd6;
    step(1);
    check("oor6_busy", 32'(busy), 32'd0);
    step(2);
    check("oor6_busy_later", 32'(busy), 32'd0);
    check("oor6_sel_act", 32'(sel_act), 32'd0);
    clk_ctl = 3'd4;
    step(2);
    check("oor4_busy", 32'(busy), 32'd0);
    check("oor4_sel_act", 32'(sel_act), 32'd0);

    // Disabled target with a low active channel switches immediately
    x = cyc;
    clk_ctl = 3'd1;
    sel_q.push_back((x + 2) * 16 + 1);
    wait_until(x + 1);
    check("dis_tgt_busy", 32'(busy), 32'd1);
    wait_until(x + 2);
    check("dis_tgt_done", 32'(busy), 32'd0);
    check("dis_tgt_act", 32'(sel_act), 32'd1);

    step(6);
    while (tick_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL tick_leftover ch=%0d got=none required_cyc=%0d", tick_q[0] % 16, tick_q[0] / 16);
      void'(tick_q.pop_front());
    end
    while (sel_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL sel_leftover got=none required=%0d at_cyc=%0d", sel_q[0] % 16, sel_q[0] / 16);
      void'(sel_q.pop_front());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
